score_scan_mux: RTL

//  Upstream feeder for the ss_decoder seven-segment decoder in the pong display path.
//  - Latches the left and right player scores and converts each to BCD tens/ones.
//  - Time-multiplexes the four digits onto the single 4-bit Din bus of ss_decoder.
//  - Drives the matching active-low anode select.
//  - Blanks the leading zero of each score.

---
 rtl/pong_disp_pkg.sv | 26 ++
 rtl/scan_tick_gen.sv | 28 ++
 rtl/score_scan_mux.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pong_disp_pkg.sv
// Shared definitions for the pong score display path: conversion FSM states,
// scan slot indices and the active-low anode pattern per slot.
package pong_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_R  = 2'd1,
        ST_DIV_L  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_e;

    localparam logic [1:0] SLOT_R1  = 2'd0;
    localparam logic [1:0] SLOT_R10 = 2'd1;
    localparam logic [1:0] SLOT_L1  = 2'd2;
    localparam logic [1:0] SLOT_L10 = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Indexed by slot: entry 0 lights the rightmost digit.
    localparam logic [3:0][3:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic logic is_tens_slot(input logic [1:0] slot);
        return (slot == SLOT_R10) || (slot == SLOT_L10);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh counter for the digit scan: counts 0..REFRESH_DIV-1 and flags the
// wrap cycle with a single-cycle tick.
module scan_tick_gen #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/score_scan_mux.sv
// Latches both player scores, converts them to BCD by repeated subtraction and
// time-multiplexes the four digits onto the seven-segment decoder input.
module score_scan_mux
    import pong_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SCORE_W     = 7,
    parameter int MAX_SCORE   = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score_l,
    input  logic [SCORE_W-1:0] score_r,
    input  logic               score_vld,
    output logic               busy,
    output logic [3:0]         digit,
    output logic [3:0]         an
);

    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] TEN   = SCORE_W'(10);

    function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
        return (s > MAX_S) ? MAX_S : s;
    endfunction

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] rem_r_q, rem_r_d, rem_l_q, rem_l_d;
    logic [3:0]         tens_r_q, tens_r_d, tens_l_q, tens_l_d;
    logic               pend_q, pend_d;
    logic [SCORE_W-1:0] pend_r_q, pend_r_d, pend_l_q, pend_l_d;
    logic [3:0][3:0]    disp_q, disp_d;   // [3]=L tens, [2]=L ones, [1]=R tens, [0]=R ones
    logic [1:0]         slot_q, slot_d;
    logic [3:0]         digit_q, digit_d;
    logic [3:0]         an_q, an_d;
    logic               tick;

    scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        rem_r_d  = rem_r_q;
        rem_l_d  = rem_l_q;
        tens_r_d = tens_r_q;
        tens_l_d = tens_l_q;
        pend_d   = pend_q;
        pend_r_d = pend_r_q;
        pend_l_d = pend_l_q;
        disp_d   = disp_q;

        // A strobe during a conversion is parked; a later strobe overwrites it.
        if (score_vld && state_q != ST_IDLE) begin
            pend_d   = 1'b1;
            pend_r_d = sat(score_r);
            pend_l_d = sat(score_l);
        end

        case (state_q)
            ST_IDLE: begin
                if (score_vld) begin
                    rem_r_d  = sat(score_r);
                    rem_l_d  = sat(score_l);
                    tens_r_d = '0;
                    tens_l_d = '0;
                    state_d  = ST_DIV_R;
                end
            end
            ST_DIV_R: begin
                if (rem_r_q >= TEN) begin
                    rem_r_d  = rem_r_q - TEN;
                    tens_r_d = tens_r_q + 4'd1;
                end else begin
                    state_d = ST_DIV_L;
                end
            end
            ST_DIV_L: begin
                if (rem_l_q >= TEN) begin
                    rem_l_d  = rem_l_q - TEN;
                    tens_l_d = tens_l_q + 4'd1;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d = {tens_l_q, rem_l_q[3:0], tens_r_q, rem_r_q[3:0]};
                tens_r_d = '0;
                tens_l_d = '0;
                // A strobe landing on this very cycle is newer than anything parked.
                if (score_vld) begin
                    rem_r_d = sat(score_r);
                    rem_l_d = sat(score_l);
                    pend_d  = 1'b0;
                    state_d = ST_DIV_R;
                end else if (pend_q) begin
                    rem_r_d = pend_r_q;
                    rem_l_d = pend_l_q;
                    pend_d  = 1'b0;
                    state_d = ST_DIV_R;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_d  = slot_q;
        digit_d = digit_q;
        an_d    = an_q;
        // digit and anode change together, only on the wrap edge.
        if (tick) begin
            digit_d = disp_q[slot_q];
            an_d    = (is_tens_slot(slot_q) && disp_q[slot_q] == 4'd0) ? AN_OFF
                                                                        : AN_TABLE[slot_q];
            slot_d  = slot_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_r_q  <= '0;
            rem_l_q  <= '0;
            tens_r_q <= '0;
            tens_l_q <= '0;
            pend_q   <= 1'b0;
            pend_r_q <= '0;
            pend_l_q <= '0;
            disp_q   <= '0;
            slot_q   <= SLOT_R1;
            digit_q  <= '0;
            an_q     <= AN_OFF;
        end else begin
            state_q  <= state_d;
            rem_r_q  <= rem_r_d;
            rem_l_q  <= rem_l_d;
            tens_r_q <= tens_r_d;
            tens_l_q <= tens_l_d;
            pend_q   <= pend_d;
            pend_r_q <= pend_r_d;
            pend_l_q <= pend_l_d;
            disp_q   <= disp_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            an_q     <= an_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign digit = digit_q;
    assign an    = an_q;

endmodule
